exc_ctrl: RTL and testbench

Exception and return controller for the pipelined WISC processor. It sits beside the decode stage and consumes the decoder's `siic`, `rti`, `err` and `Halt` strobes. It saves the return PC into EPC and issues a one-cycle PC redirect plus pipeline flush, to the handler on `siic` or an illegal opcode and back to EPC on `rti`. It then holds fetch for a fixed drain period and tracks handler state.

---
 rtl/exc_ctrl.sv | 170 +++++++++++++++++
 tb/tb_exc_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/exc_ctrl.sv
// Exception/return controller beside the WISC decode stage: EPC save, PC redirect + flush, drain hold.
// Define EXC_ILLEGAL_TRAP_EN to trap illegal opcodes to HANDLER_ADDR; otherwise an illegal opcode halts.
module exc_ctrl #(
    parameter logic [15:0] HANDLER_ADDR = 16'h0002,
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid,
    input  logic        stall,
    input  logic        siic,
    input  logic        rti,
    input  logic        err,
    input  logic        halt,
    input  logic [15:0] pc_plus2,
    output logic        redirect,
    output logic [15:0] redirect_pc,
    output logic        flush,
    output logic        fetch_hold,
    output logic [15:0] epc,
    output logic [1:0]  ecause,
    output logic        in_handler,
    output logic        halted
);

    localparam int unsigned PC_W  = 16;
    localparam int unsigned CNT_W = 3;
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES);
    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_SIIC = 2'b01;
    localparam logic [1:0] CAUSE_ILL  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REDIR   = 3'd1,
        S_DRAIN   = 3'd2,
        S_HANDLER = 3'd3,
        S_HALT    = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic              ret_hdl_q, ret_hdl_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PC_W-1:0]   epc_q, epc_d;
    logic [1:0]        ecause_q, ecause_d;
    logic [PC_W-1:0]   rpc_q, rpc_d;
    logic              redirect_q, redirect_d;
    logic              flush_q, flush_d;
    logic              fetch_hold_q, fetch_hold_d;
    logic              in_handler_q, in_handler_d;
    logic              halted_q, halted_d;
    logic              accept;

    // Next-state, saved context and registered outputs derived from the next state.
    always_comb begin
        state_d   = state_q;
        ret_hdl_d = ret_hdl_q;
        cnt_d     = cnt_q;
        epc_d     = epc_q;
        ecause_d  = ecause_q;
        rpc_d     = rpc_q;
        accept    = valid && !stall && (state_q == S_IDLE || state_q == S_HANDLER);

        case (state_q)
            S_IDLE, S_HANDLER: begin
                if (accept) begin
                    if (halt) begin
                        state_d = S_HALT;
                    end else if (err) begin
`ifdef EXC_ILLEGAL_TRAP_EN
                        if (state_q == S_IDLE) begin
                            state_d   = S_REDIR;
                            epc_d     = pc_plus2;
                            ecause_d  = CAUSE_ILL;
                            rpc_d     = HANDLER_ADDR;
                            ret_hdl_d = 1'b1;
                        end else begin
                            state_d = S_HALT;
                        end
`else
                        state_d  = S_HALT;
                        ecause_d = CAUSE_ILL;
`endif
                    end else if (siic) begin
                        // A trap taken inside the handler would clobber EPC, so it halts instead.
                        if (state_q == S_IDLE) begin
                            state_d   = S_REDIR;
                            epc_d     = pc_plus2;
                            ecause_d  = CAUSE_SIIC;
                            rpc_d     = HANDLER_ADDR;
                            ret_hdl_d = 1'b1;
                        end else begin
                            state_d = S_HALT;
                        end
                    end else if (rti) begin
                        state_d   = S_REDIR;
                        rpc_d     = epc_q;
                        ret_hdl_d = 1'b0;
                    end
                end
            end
            S_REDIR: begin
                state_d = S_DRAIN;
                cnt_d   = DRAIN_LOAD;
            end
            S_DRAIN: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ret_hdl_q ? S_HANDLER : S_IDLE;
                    cnt_d   = '0;
                    if (!ret_hdl_q) begin
                        ecause_d = CAUSE_NONE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        redirect_d   = (state_d == S_REDIR);
        flush_d      = (state_d == S_REDIR);
        fetch_hold_d = (state_d == S_DRAIN) || (state_d == S_HALT);
        in_handler_d = (state_d == S_HANDLER) ||
                       (((state_d == S_REDIR) || (state_d == S_DRAIN)) && ret_hdl_d);
        halted_d     = (state_d == S_HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            ret_hdl_q    <= 1'b0;
            cnt_q        <= '0;
            epc_q        <= '0;
            ecause_q     <= CAUSE_NONE;
            rpc_q        <= '0;
            redirect_q   <= 1'b0;
            flush_q      <= 1'b0;
            fetch_hold_q <= 1'b0;
            in_handler_q <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            ret_hdl_q    <= ret_hdl_d;
            cnt_q        <= cnt_d;
            epc_q        <= epc_d;
            ecause_q     <= ecause_d;
            rpc_q        <= rpc_d;
            redirect_q   <= redirect_d;
            flush_q      <= flush_d;
            fetch_hold_q <= fetch_hold_d;
            in_handler_q <= in_handler_d;
            halted_q     <= halted_d;
        end
    end

    assign redirect    = redirect_q;
    assign redirect_pc = rpc_q;
    assign flush       = flush_q;
    assign fetch_hold  = fetch_hold_q;
    assign epc         = epc_q;
    assign ecause      = ecause_q;
    assign in_handler  = in_handler_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Scoreboard bench for exc_ctrl: a countdown-based reference model predicts per-cycle outputs and redirect targets.
module tb_exc_ctrl;

    localparam logic [15:0] HADDR = 16'h0002;
    localparam int          DRAIN = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0, stall = 1'b0, siic = 1'b0, rti = 1'b0, err = 1'b0, halt = 1'b0;
    logic [15:0] pc_plus2 = 16'h0;
    logic        redirect, flush, fetch_hold, in_handler, halted;
    logic [15:0] redirect_pc, epc;
    logic [1:0]  ecause;

    exc_ctrl #(.HANDLER_ADDR(HADDR), .DRAIN_CYCLES(DRAIN)) dut (
        .clk(clk), .rst_n(rst_n), .valid(valid), .stall(stall), .siic(siic), .rti(rti),
        .err(err), .halt(halt), .pc_plus2(pc_plus2), .redirect(redirect),
        .redirect_pc(redirect_pc), .flush(flush), .fetch_hold(fetch_hold), .epc(epc),
        .ecause(ecause), .in_handler(in_handler), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        red;
        logic        fl;
        logic        fh;
        logic        ih;
        logic        hl;
        logic [15:0] epc;
        logic [1:0]  cause;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] ev_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;

    // Reference model: mode 0 idle, 1 in handler, 2 halted; busy counts redirect+drain cycles left.
    int          m_mode = 0;
    int          m_busy = 0;
    int          m_ret  = 0;
    logic [15:0] m_epc  = 16'h0;
    logic [1:0]  m_cause = 2'b00;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endfunction

    task automatic m_trap(input logic [15:0] pc, input logic [1:0] cause);
        m_epc   = pc;
        m_cause = cause;
        m_ret   = 1;
        m_busy  = DRAIN + 1;
        ev_q.push_back(HADDR);
    endtask

    task automatic cyc(input logic r, input logic v, input logic st, input logic s,
                       input logic rt, input logic e, input logic h, input logic [15:0] pc);
        exp_t x;
        @(negedge clk);
        rst_n = r; valid = v; stall = st; siic = s; rti = rt; err = e; halt = h; pc_plus2 = pc;
        if (!r) begin
            #1;
            chk("rst_ctrl", 32'({redirect, flush, fetch_hold, in_handler, halted, ecause}), 32'd0);
            chk("rst_epc", 32'(epc), 32'd0);
            chk("rst_rpc", 32'(redirect_pc), 32'd0);
            m_mode = 0; m_busy = 0; m_ret = 0; m_epc = 16'h0; m_cause = 2'b00;
        end else if (m_mode != 2 && m_busy == 0 && v && !st) begin
            if (h) begin
                m_mode = 2;
            end else if (e) begin
`ifdef EXC_ILLEGAL_TRAP_EN
                if (m_mode == 0) m_trap(pc, 2'b10);
                else m_mode = 2;
`else
                m_mode  = 2;
                m_cause = 2'b10;
`endif
            end else if (s) begin
                if (m_mode == 0) m_trap(pc, 2'b01);
                else m_mode = 2;
            end else if (rt) begin
                m_ret  = 0;
                m_busy = DRAIN + 1;
                ev_q.push_back(m_epc);
            end
        end else if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
                m_mode = m_ret;
                if (m_ret == 0) m_cause = 2'b00;
            end
        end
        x.hl    = (m_mode == 2);
        x.red   = (m_busy == DRAIN + 1);
        x.fl    = x.red;
        x.fh    = x.hl || (m_busy > 0 && m_busy <= DRAIN);
        x.ih    = !x.hl && ((m_busy > 0) ? (m_ret == 1) : (m_mode == 1));
        x.epc   = m_epc;
        x.cause = m_cause;
        exp_q.push_back(x);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic rst(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    // Monitor: compares each post-edge output set and every redirect target against the scoreboard.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("redirect", 32'(redirect), 32'(mon_e.red));
                chk("flush", 32'(flush), 32'(mon_e.fl));
                chk("fetch_hold", 32'(fetch_hold), 32'(mon_e.fh));
                chk("in_handler", 32'(in_handler), 32'(mon_e.ih));
                chk("halted", 32'(halted), 32'(mon_e.hl));
                chk("epc", 32'(epc), 32'(mon_e.epc));
                chk("ecause", 32'(ecause), 32'(mon_e.cause));
                if (redirect === 1'b1) begin
                    if (ev_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL redirect_event actual=unexpected_pulse required=none t=%0t", $time);
                    end else begin
                        chk("redirect_pc", 32'(redirect_pc), 32'(ev_q.pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int halt_cnt;
        logic v, st, s, rt, e, h;
        logic [15:0] pc;

        rst(2);
        idle(1);

        // Handler entry, then return.
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0040);
        idle(4);
        chk("tp_entry_ih", 32'(in_handler), 32'd1);
        chk("tp_entry_epc", 32'(epc), 32'h0040);
        chk("tp_entry_cause", 32'(ecause), 32'd1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0050);
        idle(4);
        chk("tp_ret_ih", 32'(in_handler), 32'd0);
        chk("tp_ret_cause", 32'(ecause), 32'd0);

        // Nested trap halts and keeps EPC.
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0040);
        idle(4);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234);
        idle(3);
        chk("tp_nest_halted", 32'(halted), 32'd1);
        chk("tp_nest_epc", 32'(epc), 32'h0040);
        rst(2);

        // Stall defers acceptance; rti during drain is dropped.
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0200);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0200);
        idle(1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0300);
        idle(4);
        chk("tp_stall_epc", 32'(epc), 32'h0200);
        chk("tp_stall_ih", 32'(in_handler), 32'd1);
        rst(1);
        idle(1);

        // Illegal opcode.
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0100);
        idle(4);
`ifdef EXC_ILLEGAL_TRAP_EN
        chk("tp_ill_epc", 32'(epc), 32'h0100);
        chk("tp_ill_cause", 32'(ecause), 32'd2);
        chk("tp_ill_ih", 32'(in_handler), 32'd1);
`else
        chk("tp_ill_halted", 32'(halted), 32'd1);
        chk("tp_ill_epc", 32'(epc), 32'h0000);
        chk("tp_ill_cause", 32'(ecause), 32'd2);
`endif
        rst(1);
        idle(1);

        // Reset while draining.
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0300);
        idle(2);
        rst(2);
        idle(5);
        chk("tp_rst_hold", 32'(fetch_hold), 32'd0);

        // Randomized traffic; halted runs are ended by reset.
        halt_cnt = 0;
        for (int i = 0; i < 600; i++) begin
            if (m_mode == 2) halt_cnt++;
            if (halt_cnt > 3) begin
                halt_cnt = 0;
                rst(1 + int'($urandom_range(0, 1)));
            end else begin
                v  = ($urandom % 4) != 0;
                st = ($urandom % 4) == 0;
                s  = ($urandom % 8) == 0;
                rt = ($urandom % 6) == 0;
                e  = ($urandom % 16) == 0;
                h  = ($urandom % 40) == 0;
                pc = 16'($urandom) & 16'hFFFE;
                cyc(1'b1, v, st, s, rt, e, h, pc);
            end
        end
        idle(2);

        @(posedge clk);
        #4;
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        chk("ev_q_drained", 32'(ev_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
